// File: rtl/arp_over_ethernet.sv
// -----------------------------------------------------------------------------
// arp_over_ethernet
//   ARP responder sitting on the ARP port of the Ethernet switch. Captures the
//   28-byte ARP payload of each received frame, reports every well-formed
//   sender IP/MAC pair to the ARP link, and answers requests for our IP with
//   an ARP reply. The framer below adds preamble, MAC header, padding and FCS.
//
// Ports
//   i_clk, i_reset        clock, asynchronous active-high reset
//   i_mac, i_ip           our (static) MAC / IPv4 address
//   i_rx_dven/data        received payload bytes, contiguous per frame
//   i_rx_ethertype        ethertype of the frame, stable while i_rx_dven high
//   o_tx_request          reply pending, held until i_tx_grant
//   i_tx_grant            one-cycle grant from switch/framer
//   o_tx_dven/data        28-byte reply stream
//   o_tx_dmac             reply destination MAC (requester SHA)
//   o_tx_ethertype        constant ETHERTYPE_ARP
//   o_arp_valid           one-cycle pulse, o_arp_ip/o_arp_mac updated
// -----------------------------------------------------------------------------
module arp_over_ethernet #(
  parameter logic [15:0] ETHERTYPE_ARP = 16'h0806,
  parameter int          ARP_BYTES     = 28
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic [47:0] i_mac,
  input  logic [31:0] i_ip,
  input  logic        i_rx_dven,
  input  logic [7:0]  i_rx_data,
  input  logic [15:0] i_rx_ethertype,
  output logic        o_tx_request,
  input  logic        i_tx_grant,
  output logic        o_tx_dven,
  output logic [7:0]  o_tx_data,
  output logic [47:0] o_tx_dmac,
  output logic [15:0] o_tx_ethertype,
  output logic        o_arp_valid,
  output logic [31:0] o_arp_ip,
  output logic [47:0] o_arp_mac
);

  localparam int         CAP_W   = ARP_BYTES * 8;
  localparam logic [5:0] CNT_MAX = 6'(ARP_BYTES);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RX,
    S_CHECK,
    S_REQ,
    S_TX
  } state_t;

  state_t r_state, w_next;

  logic             r_rx_dven_d;
  logic [5:0]       r_cnt;
  logic [5:0]       r_txcnt;
  logic [CAP_W-1:0] r_cap;
  logic [CAP_W-1:0] r_txsh;
  logic             r_tx_request;
  logic             r_tx_dven;
  logic [7:0]       r_tx_data;
  logic [47:0]      r_tx_dmac;
  logic             r_arp_valid;
  logic [31:0]      r_arp_ip;
  logic [47:0]      r_arp_mac;

  // Field views of the capture register; byte 0 of the payload ends up in
  // the top byte after 28 shifts.
  logic [15:0]      w_htype, w_ptype, w_oper;
  logic [7:0]       w_hlen, w_plen;
  logic [47:0]      w_sha;
  logic [31:0]      w_spa, w_tpa;
  logic             w_frame_start;
  logic             w_valid;
  logic             w_reply_needed;
  logic [CAP_W-1:0] w_reply;

  assign w_htype = r_cap[CAP_W-1   -: 16];
  assign w_ptype = r_cap[CAP_W-17  -: 16];
  assign w_hlen  = r_cap[CAP_W-33  -: 8];
  assign w_plen  = r_cap[CAP_W-41  -: 8];
  assign w_oper  = r_cap[CAP_W-49  -: 16];
  assign w_sha   = r_cap[CAP_W-65  -: 48];
  assign w_spa   = r_cap[CAP_W-113 -: 32];
  assign w_tpa   = r_cap[31:0];

  // Start on the rising edge of i_rx_dven only, so the tail of a frame that
  // began while we were busy is never mistaken for a new frame.
  assign w_frame_start = i_rx_dven & ~r_rx_dven_d &
                         (i_rx_ethertype == ETHERTYPE_ARP);

  assign w_valid = (r_cnt == CNT_MAX) && (w_htype == 16'h0001) &&
                   (w_ptype == 16'h0800) && (w_hlen == 8'd6) &&
                   (w_plen == 8'd4) &&
                   ((w_oper == 16'h0001) || (w_oper == 16'h0002));

  assign w_reply_needed = w_valid && (w_oper == 16'h0001) && (w_tpa == i_ip);

  // Reply payload in wire order; requester SHA/SPA become target fields.
  assign w_reply = {16'h0001, 16'h0800, 8'h06, 8'h04, 16'h0002,
                    i_mac, i_ip, w_sha, w_spa};

  // ---------------------------------------------------------------------------
  // FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) r_state <= S_IDLE;
    else         r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (w_frame_start) w_next = S_RX;
      S_RX:    if (!i_rx_dven) w_next = S_CHECK;
      S_CHECK: w_next = w_reply_needed ? S_REQ : S_IDLE;
      S_REQ:   if (i_tx_grant) w_next = S_TX;
      S_TX:    if (r_txcnt == CNT_MAX) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Datapath and registered outputs
  // ---------------------------------------------------------------------------
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_rx_dven_d  <= 1'b0;
      r_cnt        <= '0;
      r_txcnt      <= '0;
      r_cap        <= '0;
      r_txsh       <= '0;
      r_tx_request <= 1'b0;
      r_tx_dven    <= 1'b0;
      r_tx_data    <= '0;
      r_tx_dmac    <= '0;
      r_arp_valid  <= 1'b0;
      r_arp_ip     <= '0;
      r_arp_mac    <= '0;
    end else begin
      r_rx_dven_d <= i_rx_dven;
      r_arp_valid <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_frame_start) begin
            r_cap <= {r_cap[CAP_W-9:0], i_rx_data};
            r_cnt <= 6'd1;
          end
        end
        S_RX: begin
          if (i_rx_dven) begin
            // Counter saturates at 28; pad bytes after that are dropped.
            if (r_cnt < CNT_MAX) begin
              r_cap <= {r_cap[CAP_W-9:0], i_rx_data};
              r_cnt <= r_cnt + 6'd1;
            end
          end else if (w_valid) begin
            // Registered so the pulse lands in the CHECK cycle.
            r_arp_valid <= 1'b1;
            r_arp_ip    <= w_spa;
            r_arp_mac   <= w_sha;
          end
        end
        S_CHECK: begin
          if (w_reply_needed) begin
            r_tx_request <= 1'b1;
            r_tx_dmac    <= w_sha;
          end
        end
        S_REQ: begin
          if (i_tx_grant) begin
            r_tx_request <= 1'b0;
            r_tx_dven    <= 1'b1;
            r_tx_data    <= w_reply[CAP_W-1 -: 8];
            r_txsh       <= {w_reply[CAP_W-9:0], 8'h00};
            r_txcnt      <= 6'd1;
          end
        end
        S_TX: begin
          // r_txcnt counts bytes already presented on o_tx_data.
          if (r_txcnt == CNT_MAX) begin
            r_tx_dven <= 1'b0;
            r_tx_data <= '0;
            r_txcnt   <= '0;
          end else begin
            r_tx_data <= r_txsh[CAP_W-1 -: 8];
            r_txsh    <= {r_txsh[CAP_W-9:0], 8'h00};
            r_txcnt   <= r_txcnt + 6'd1;
          end
        end
        default: ;
      endcase
    end
  end

  assign o_tx_request   = r_tx_request;
  assign o_tx_dven      = r_tx_dven;
  assign o_tx_data      = r_tx_data;
  assign o_tx_dmac      = r_tx_dmac;
  assign o_tx_ethertype = ETHERTYPE_ARP;
  assign o_arp_valid    = r_arp_valid;
  assign o_arp_ip       = r_arp_ip;
  assign o_arp_mac      = r_arp_mac;

endmodule

// File: tb/tb_arp_over_ethernet.sv
// -----------------------------------------------------------------------------
// tb_arp_over_ethernet
//   Directed + randomized bench for arp_over_ethernet. Frames are built as
//   byte queues; the reference model derives validity, reply decision and the
//   expected reply bytes directly from the ARP field rules on those bytes.
// -----------------------------------------------------------------------------
module tb_arp_over_ethernet;

  localparam logic [47:0] MAC = 48'h503eaa059701;
  localparam logic [31:0] IP  = 32'hc0a801e0;
  localparam logic [15:0] ET_ARP = 16'h0806;

  logic        clk = 1'b0;
  logic        reset;
  logic        rx_dven;
  logic [7:0]  rx_data;
  logic [15:0] rx_ethertype;
  logic        tx_request;
  logic        tx_grant;
  logic        tx_dven;
  logic [7:0]  tx_data;
  logic [47:0] tx_dmac;
  logic [15:0] tx_ethertype;
  logic        arp_valid;
  logic [31:0] arp_ip;
  logic [47:0] arp_mac;

  arp_over_ethernet dut (
    .i_clk          (clk),
    .i_reset        (reset),
    .i_mac          (MAC),
    .i_ip           (IP),
    .i_rx_dven      (rx_dven),
    .i_rx_data      (rx_data),
    .i_rx_ethertype (rx_ethertype),
    .o_tx_request   (tx_request),
    .i_tx_grant     (tx_grant),
    .o_tx_dven      (tx_dven),
    .o_tx_data      (tx_data),
    .o_tx_dmac      (tx_dmac),
    .o_tx_ethertype (tx_ethertype),
    .o_arp_valid    (arp_valid),
    .o_arp_ip       (arp_ip),
    .o_arp_mac      (arp_mac)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int valid_pulses = 0;

  always @(negedge clk) if (arp_valid === 1'b1) valid_pulses++;

  logic [7:0]  frm[$];
  logic [7:0]  exp_tx[$];
  logic        m_valid, m_reply;
  logic [47:0] m_sha;
  logic [31:0] m_spa;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic void build(input logic [15:0] htype, input logic [15:0] ptype,
                                input logic [7:0] hlen, input logic [7:0] plen,
                                input logic [15:0] oper, input logic [47:0] sha,
                                input logic [31:0] spa, input logic [31:0] tpa,
                                input int npad);
    frm.delete();
    frm.push_back(htype[15:8]); frm.push_back(htype[7:0]);
    frm.push_back(ptype[15:8]); frm.push_back(ptype[7:0]);
    frm.push_back(hlen);        frm.push_back(plen);
    frm.push_back(oper[15:8]);  frm.push_back(oper[7:0]);
    for (int i = 5; i >= 0; i--) frm.push_back(sha[8*i +: 8]);
    for (int i = 3; i >= 0; i--) frm.push_back(spa[8*i +: 8]);
    for (int i = 0; i < 6; i++)  frm.push_back(8'h00);
    for (int i = 3; i >= 0; i--) frm.push_back(tpa[8*i +: 8]);
    for (int i = 0; i < npad; i++) frm.push_back(8'($urandom));
  endfunction

  // Reference model: ARP rules applied to the byte queue.
  function automatic void model(input logic [15:0] etype);
    logic [15:0] htype, ptype, oper;
    logic [31:0] tpa;
    logic [63:0] hdr;
    m_valid = 1'b0; m_reply = 1'b0; m_sha = '0; m_spa = '0; tpa = '0;
    exp_tx.delete();
    if (etype == ET_ARP && frm.size() >= 28) begin
      htype = {frm[0], frm[1]};
      ptype = {frm[2], frm[3]};
      oper  = {frm[6], frm[7]};
      for (int i = 0; i < 6; i++) m_sha = {m_sha[39:0], frm[8+i]};
      for (int i = 0; i < 4; i++) m_spa = {m_spa[23:0], frm[14+i]};
      for (int i = 0; i < 4; i++) tpa   = {tpa[23:0], frm[24+i]};
      m_valid = htype == 16'h0001 && ptype == 16'h0800 && frm[4] == 8'd6 &&
                frm[5] == 8'd4 && (oper == 16'd1 || oper == 16'd2);
      m_reply = m_valid && oper == 16'd1 && tpa == IP;
    end
    hdr = 64'h0001080006040002;
    for (int i = 7; i >= 0; i--) exp_tx.push_back(hdr[8*i +: 8]);
    for (int i = 5; i >= 0; i--) exp_tx.push_back(MAC[8*i +: 8]);
    for (int i = 3; i >= 0; i--) exp_tx.push_back(IP[8*i +: 8]);
    for (int i = 5; i >= 0; i--) exp_tx.push_back(m_sha[8*i +: 8]);
    for (int i = 3; i >= 0; i--) exp_tx.push_back(m_spa[8*i +: 8]);
  endfunction

  task automatic send_frame(input logic [15:0] etype);
    for (int i = 0; i < frm.size(); i++) begin
      @(negedge clk);
      rx_dven = 1'b1; rx_data = frm[i]; rx_ethertype = etype;
    end
    @(negedge clk);
    rx_dven = 1'b0; rx_data = 8'h00;
  endtask

  // Checks the two edges following the end of a frame.
  task automatic post_checks();
    @(posedge clk); #1;
    chk("arp_valid", arp_valid, m_valid);
    if (m_valid) begin
      chk("arp_ip", arp_ip, m_spa);
      chk("arp_mac", arp_mac, m_sha);
    end
    chk("req_early", tx_request, 1'b0);
    @(posedge clk); #1;
    chk("arp_valid_1cyc", arp_valid, 1'b0);
    chk("tx_request", tx_request, m_reply);
    if (m_reply) chk("tx_dmac", tx_dmac, m_sha);
  endtask

  task automatic hold_req(input int n);
    logic bad = 1'b0;
    for (int c = 0; c < n; c++) begin
      @(posedge clk); #1;
      if (tx_request !== 1'b1 || tx_dmac !== m_sha || tx_dven !== 1'b0) bad = 1'b1;
    end
    chk("req_hold", bad, 1'b0);
  endtask

  task automatic collect();
    logic bad = 1'b0;
    @(negedge clk); tx_grant = 1'b1;
    @(posedge clk); #1; tx_grant = 1'b0;
    chk("req_drop", tx_request, 1'b0);
    for (int i = 0; i < 28; i++) begin
      if (i > 0) begin @(posedge clk); #1; end
      if (tx_dven !== 1'b1 || tx_dmac !== m_sha) bad = 1'b1;
      chk($sformatf("tx_byte%0d", i), tx_data, exp_tx[i]);
    end
    chk("tx_dven_28", bad, 1'b0);
    @(posedge clk); #1;
    chk("tx_dven_end", tx_dven, 1'b0);
  endtask

  task automatic idle_checks();
    logic bad = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
      if (tx_request !== 1'b0 || tx_dven !== 1'b0) bad = 1'b1;
    end
    chk("no_reply", bad, 1'b0);
  endtask

  task automatic run_frame(input logic [15:0] etype, input int hold);
    int v0;
    model(etype);
    v0 = valid_pulses;
    send_frame(etype);
    post_checks();
    if (m_reply) begin
      hold_req(hold);
      collect();
    end else begin
      idle_checks();
    end
    chk("valid_count", valid_pulses - v0, m_valid);
  endtask

  initial begin
    logic [47:0] sha;
    logic [31:0] spa;
    int typ, v0;

    reset = 1'b1; rx_dven = 1'b0; rx_data = 8'h00; rx_ethertype = 16'h0000;
    tx_grant = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_tx_request", tx_request, 1'b0);
    chk("rst_tx_dven", tx_dven, 1'b0);
    chk("rst_tx_data", tx_data, 8'h00);
    chk("rst_tx_dmac", tx_dmac, 48'h0);
    chk("rst_arp_valid", arp_valid, 1'b0);
    chk("rst_arp_ip", arp_ip, 32'h0);
    chk("rst_arp_mac", arp_mac, 48'h0);
    chk("tx_ethertype", tx_ethertype, ET_ARP);
    @(negedge clk); reset = 1'b0;
    repeat (2) @(negedge clk);

    // Request for our IP with 18 pad bytes.
    build(16'h1, 16'h0800, 8'd6, 8'd4, 16'd1, 48'hc46e1f01d90d, 32'hc0a801c8, IP, 18);
    run_frame(ET_ARP, 0);

    // Request for a different IP: learn only.
    build(16'h1, 16'h0800, 8'd6, 8'd4, 16'd1, 48'hc46e1f01d90d, 32'hc0a801c8, 32'hc0a801e1, 18);
    run_frame(ET_ARP, 0);

    // Reply frame (OPER=2).
    build(16'h1, 16'h0800, 8'd6, 8'd4, 16'd2, 48'h112233445566, 32'h0a000001, IP, 18);
    run_frame(ET_ARP, 0);

    // Truncated to 20 bytes.
    build(16'h1, 16'h0800, 8'd6, 8'd4, 16'd1, 48'hc46e1f01d90d, 32'hc0a801c8, IP, 0);
    while (frm.size() > 20) void'(frm.pop_back());
    run_frame(ET_ARP, 0);

    // PTYPE 0x86dd.
    build(16'h1, 16'h86dd, 8'd6, 8'd4, 16'd1, 48'hc46e1f01d90d, 32'hc0a801c8, IP, 18);
    run_frame(ET_ARP, 0);

    // Non-ARP ethertype.
    build(16'h1, 16'h0800, 8'd6, 8'd4, 16'd1, 48'hc46e1f01d90d, 32'hc0a801c8, IP, 18);
    run_frame(16'h0800, 0);

    // Grant withheld ~50 cycles with a second request arriving during REQ.
    build(16'h1, 16'h0800, 8'd6, 8'd4, 16'd1, 48'ha0b0c0d0e0f0, 32'hc0a80105, IP, 18);
    model(ET_ARP);
    v0 = valid_pulses;
    send_frame(ET_ARP);
    post_checks();
    build(16'h1, 16'h0800, 8'd6, 8'd4, 16'd1, 48'h0a0b0c0d0e0f, 32'hc0a80106, IP, 18);
    send_frame(ET_ARP);
    hold_req(3);
    chk("req_during_req_ignored", valid_pulses - v0, 1);
    collect();
    idle_checks();

    // Reset in the middle of TX.
    build(16'h1, 16'h0800, 8'd6, 8'd4, 16'd1, 48'hc46e1f01d90d, 32'hc0a801c8, IP, 18);
    model(ET_ARP);
    send_frame(ET_ARP);
    post_checks();
    @(negedge clk); tx_grant = 1'b1;
    @(posedge clk); #1; tx_grant = 1'b0;
    chk("abort_byte0", tx_data, exp_tx[0]);
    repeat (9) @(posedge clk);
    #1;
    chk("abort_byte9", tx_data, exp_tx[9]);
    @(negedge clk); reset = 1'b1;
    @(posedge clk); #1;
    chk("abort_tx_dven", tx_dven, 1'b0);
    chk("abort_tx_data", tx_data, 8'h00);
    chk("abort_tx_dmac", tx_dmac, 48'h0);
    chk("abort_tx_request", tx_request, 1'b0);
    chk("abort_arp_ip", arp_ip, 32'h0);
    chk("abort_arp_mac", arp_mac, 48'h0);
    @(negedge clk); reset = 1'b0;
    idle_checks();
    run_frame(ET_ARP, 2);

    // Randomized frames.
    for (int n = 0; n < 30; n++) begin
      sha = {16'($urandom), 32'($urandom)};
      spa = 32'($urandom);
      typ = int'($urandom_range(0, 5));
      case (typ)
        0: build(16'h1, 16'h0800, 8'd6, 8'd4, 16'd1, sha, spa, IP, int'($urandom_range(0, 18)));
        1: build(16'h1, 16'h0800, 8'd6, 8'd4, 16'd1, sha, spa,
                 IP ^ 32'($urandom_range(1, 255)), int'($urandom_range(0, 18)));
        2: build(16'h1, 16'h0800, 8'd6, 8'd4, 16'd2, sha, spa, 32'($urandom), 18);
        3: begin
          build(16'h1, 16'h0800, 8'd6, 8'd4, 16'd1, sha, spa, IP, 0);
          typ = int'($urandom_range(1, 27));
          while (frm.size() > typ) void'(frm.pop_back());
        end
        4: begin
          case ($urandom_range(0, 4))
            0: build(16'h2, 16'h0800, 8'd6, 8'd4, 16'd1, sha, spa, IP, 18);
            1: build(16'h1, 16'h86dd, 8'd6, 8'd4, 16'd1, sha, spa, IP, 18);
            2: build(16'h1, 16'h0800, 8'd8, 8'd4, 16'd1, sha, spa, IP, 18);
            3: build(16'h1, 16'h0800, 8'd6, 8'd16, 16'd1, sha, spa, IP, 18);
            default: build(16'h1, 16'h0800, 8'd6, 8'd4, 16'd3, sha, spa, IP, 18);
          endcase
        end
        default: build(16'h1, 16'h0800, 8'd6, 8'd4, 16'd1, sha, spa, IP, 18);
      endcase
      run_frame((typ == 5) ? 16'h86dd : ET_ARP, int'($urandom_range(0, 5)));
      repeat ($urandom_range(1, 3)) @(negedge clk);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
